// File: rtl/cmd_receiver_pkg.sv
// Shared types and default sizing for the write-command receiver.
package cmd_receiver_pkg;

  localparam int unsigned ID_SZ      = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    OpDel = 2'b00,
    OpIns = 2'b01,
    OpChk = 2'b10
  } opcode_e;

endpackage

// File: rtl/cmd_receiver_if.sv
// Command and response channels of the receiver, plus its status outputs.
interface cmd_receiver_if
  import cmd_receiver_pkg::*;
#(
  parameter int unsigned ID_SZ = cmd_receiver_pkg::ID_SZ,
  parameter int unsigned CNT_W = 16
);

  logic             wrm;
  logic             wrs;
  opcode_e          wop;
  logic             wmo;
  logic [ID_SZ-1:0] wid;
  logic             rsp_vld;
  logic             rsp_rdy;
  opcode_e          rsp_op;
  logic [ID_SZ-1:0] rsp_id;
  logic             rsp_hit;
  logic [ID_SZ:0]   occ;
  logic [CNT_W-1:0] acc_cnt;

  modport master (
    output wrm, wop, wmo, wid, rsp_rdy,
    input  wrs, rsp_vld, rsp_op, rsp_id, rsp_hit, occ, acc_cnt
  );

  modport slave (
    input  wrm, wop, wmo, wid, rsp_rdy,
    output wrs, rsp_vld, rsp_op, rsp_id, rsp_hit, occ, acc_cnt
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO, power-of-two depth; push ignored when full, pop ignored when empty.
module cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AddrW + 1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AddrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    // Pointers wrap naturally because Depth is a power of two.
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AddrW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AddrW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cmd_receiver.sv
// Buffers write commands, executes them in order against a presence table, and
// returns a response beat for every command that asks for one.
module cmd_receiver
  import cmd_receiver_pkg::*;
#(
  parameter int unsigned ID_SZ      = cmd_receiver_pkg::ID_SZ,
  parameter int unsigned FIFO_DEPTH = cmd_receiver_pkg::FIFO_DEPTH,
  parameter int unsigned CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  cmd_receiver_if.slave bus
);

  localparam int unsigned OpW  = $bits(opcode_e);
  localparam int unsigned CmdW = OpW + 1 + ID_SZ;
  localparam int unsigned TblN = 2 ** ID_SZ;

  logic [CmdW-1:0]  fifo_din, fifo_dout;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  opcode_e          head_op;
  logic             head_mode;
  logic [ID_SZ-1:0] head_id;
  logic             hit;

  logic [TblN-1:0]  tbl_q, tbl_d;
  logic [ID_SZ:0]   occ_q, occ_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             rsp_vld_q, rsp_vld_d;
  opcode_e          rsp_op_q, rsp_op_d;
  logic [ID_SZ-1:0] rsp_id_q, rsp_id_d;
  logic             rsp_hit_q, rsp_hit_d;

  assign fifo_din  = {bus.wop, bus.wmo, bus.wid};
  assign head_op   = opcode_e'(fifo_dout[CmdW-1 -: OpW]);
  assign head_mode = fifo_dout[ID_SZ];
  assign head_id   = fifo_dout[ID_SZ-1:0];
  assign hit       = tbl_q[head_id];

  // No pass-through when full: ready depends on registered occupancy only.
  assign bus.wrs = rst && !fifo_full;
  assign push    = bus.wrm && bus.wrs;
  assign pop     = !fifo_empty && (!rsp_vld_q || bus.rsp_rdy);

  cmd_fifo #(
    .Width (CmdW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    tbl_d     = tbl_q;
    occ_d     = occ_q;
    acc_cnt_d = acc_cnt_q;
    rsp_vld_d = rsp_vld_q;
    rsp_op_d  = rsp_op_q;
    rsp_id_d  = rsp_id_q;
    rsp_hit_d = rsp_hit_q;

    if (push) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
    if (bus.rsp_rdy) begin
      rsp_vld_d = 1'b0;
    end

    if (pop) begin
      case (head_op)
        OpIns: begin
          tbl_d[head_id] = 1'b1;
          if (!hit) occ_d = occ_q + (ID_SZ + 1)'(1);
        end
        OpDel: begin
          tbl_d[head_id] = 1'b0;
          if (hit) occ_d = occ_q - (ID_SZ + 1)'(1);
        end
        default: ;
      endcase
      if (head_mode) begin
        rsp_vld_d = 1'b1;
        rsp_op_d  = head_op;
        rsp_id_d  = head_id;
        rsp_hit_d = hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tbl_q     <= '0;
      occ_q     <= '0;
      acc_cnt_q <= '0;
      rsp_vld_q <= 1'b0;
      rsp_op_q  <= OpDel;
      rsp_id_q  <= '0;
      rsp_hit_q <= 1'b0;
    end else begin
      tbl_q     <= tbl_d;
      occ_q     <= occ_d;
      acc_cnt_q <= acc_cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_op_q  <= rsp_op_d;
      rsp_id_q  <= rsp_id_d;
      rsp_hit_q <= rsp_hit_d;
    end
  end

  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_op  = rsp_op_q;
  assign bus.rsp_id  = rsp_id_q;
  assign bus.rsp_hit = rsp_hit_q;
  assign bus.occ     = occ_q;
  assign bus.acc_cnt = acc_cnt_q;

endmodule

// File: tb/tb_cmd_receiver.sv
// Self-checking bench for cmd_receiver against a sequential presence-table model.
module tb_cmd_receiver;
  import cmd_receiver_pkg::*;

  localparam int unsigned IdW = ID_SZ;
  localparam int unsigned NId = 2 ** ID_SZ;
  localparam int unsigned CntW = 16;

  typedef struct {
    opcode_e        op;
    logic [IdW-1:0] id;
    logic           hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_receiver_if #(.ID_SZ(IdW), .CNT_W(CntW)) bus ();

  cmd_receiver #(
    .ID_SZ      (IdW),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  bit   tbl[NId];
  int   acc_model;
  int   checks;
  int   failures;
  int   rsp_seen;
  logic last_hit;

  function automatic int model_occ();
    int n = 0;
    foreach (tbl[i]) n += int'(tbl[i]);
    return n;
  endfunction

  function automatic void model_clear();
    foreach (tbl[i]) tbl[i] = 1'b0;
    exp_q.delete();
    acc_model = 0;
  endfunction

  // Commands execute in acceptance order, so the model applies each one immediately.
  function automatic void model_accept(opcode_e op, logic mode, logic [IdW-1:0] id);
    exp_t e;
    acc_model++;
    e.op  = op;
    e.id  = id;
    e.hit = tbl[id];
    if (op == OpIns) tbl[id] = 1'b1;
    else if (op == OpDel) tbl[id] = 1'b0;
    if (mode) exp_q.push_back(e);
  endfunction

  function automatic opcode_e rand_op();
    logic [1:0] r;
    r = 2'($urandom_range(0, 3));
    return opcode_e'(r);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && bus.rsp_vld === 1'b1 && bus.rsp_rdy === 1'b1) begin
      rsp_seen++;
      last_hit = bus.rsp_hit;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got op=%0d id=%0d hit=%0b want no response",
                 bus.rsp_op, bus.rsp_id, bus.rsp_hit);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_op !== e.op || bus.rsp_id !== e.id || bus.rsp_hit !== e.hit) begin
          failures++;
          $display("FAIL rsp_fields got op=%0d id=%0d hit=%0b want op=%0d id=%0d hit=%0b",
                   bus.rsp_op, bus.rsp_id, bus.rsp_hit, e.op, e.id, e.hit);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input opcode_e op, input logic mode, input logic [IdW-1:0] id,
                      output int waited);
    bit done = 1'b0;
    waited   = 0;
    bus.wrm  = 1'b1;
    bus.wop  = op;
    bus.wmo  = mode;
    bus.wid  = id;
    while (!done) begin
      @(negedge clk);
      if (bus.wrs === 1'b1) begin
        model_accept(op, mode, id);
        done = 1'b1;
      end else if (waited >= 300) begin
        checks++;
        failures++;
        $display("FAIL send_timeout got wrs=%b want 1 within 300 cycles", bus.wrs);
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    bus.wrm = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.rsp_rdy = 1'b1;
    while ((exp_q.size() != 0 || bus.rsp_vld !== 1'b0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
    end
    repeat (FIFO_DEPTH + 2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst     = 1'b0;
    bus.wrm = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_clear();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (bus.wrs !== 1'b0) begin
      failures++; $display("FAIL reset_wrs got %b want 0", bus.wrs);
    end
    if (bus.rsp_vld !== 1'b0 || bus.rsp_op !== OpDel || bus.rsp_id !== '0
        || bus.rsp_hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp got vld=%b op=%0d id=%0d hit=%b want 0 0 0 0",
               bus.rsp_vld, bus.rsp_op, bus.rsp_id, bus.rsp_hit);
    end
    if (bus.occ !== '0) begin
      failures++; $display("FAIL reset_occ got %0d want 0", bus.occ);
    end
    if (bus.acc_cnt !== '0) begin
      failures++; $display("FAIL reset_acc got %0d want 0", bus.acc_cnt);
    end
    model_clear();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.wrs !== 1'b1) begin
      failures++; $display("FAIL reset_release_wrs got %b want 1", bus.wrs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    opcode_e ops[3]     = '{OpChk, OpDel, OpChk};
    int      occ_exp[3] = '{1, 0, 0};
    int      w;
    do_reset(1);
    bus.rsp_rdy = 1'b1;
    bus.wrm = 1'b1; bus.wop = OpIns; bus.wmo = 1'b1; bus.wid = IdW'(3);
    @(negedge clk);
    checks++;
    if (bus.wrs !== 1'b1) begin
      failures++; $display("FAIL stream_first_wrs got %b want 1", bus.wrs);
    end
    model_accept(OpIns, 1'b1, IdW'(3));
    @(posedge clk);
    #1;
    bus.wrm = 1'b0;
    checks++;
    if (bus.rsp_vld !== 1'b0) begin
      failures++; $display("FAIL stream_latency_early got vld=%b want 0", bus.rsp_vld);
    end
    @(posedge clk);
    #1;
    checks += 2;
    if (bus.rsp_vld !== 1'b1 || bus.rsp_id !== IdW'(3)) begin
      failures++;
      $display("FAIL stream_latency got vld=%b id=%0d want 1 3", bus.rsp_vld, bus.rsp_id);
    end
    if (bus.occ !== (IdW + 1)'(1)) begin
      failures++; $display("FAIL stream_occ0 got %0d want 1", bus.occ);
    end
    for (int i = 0; i < 3; i++) begin
      send(ops[i], 1'b1, IdW'(3), w);
      drain();
      checks++;
      if (bus.occ !== (IdW + 1)'(occ_exp[i])) begin
        failures++; $display("FAIL stream_occ%0d got %0d want %0d", i + 1, bus.occ, occ_exp[i]);
      end
    end
    checks++;
    if (bus.acc_cnt !== CntW'(4)) begin
      failures++; $display("FAIL stream_acc got %0d want 4", bus.acc_cnt);
    end
  endtask

  task automatic test_stall();
    int   w;
    int   base;
    exp_t head;
    do_reset(1);
    base = rsp_seen;
    bus.rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(rand_op(), 1'b1, IdW'($urandom), w);
      checks++;
      if (w != 0) begin
        failures++; $display("FAIL stall_accept%0d got wait=%0d want 0", i, w);
      end
    end
    head = exp_q[0];
    for (int c = 0; c < 4; c++) begin
      checks += 2;
      if (bus.wrs !== 1'b0) begin
        failures++; $display("FAIL stall_wrs cyc%0d got %b want 0", c, bus.wrs);
      end
      if (bus.rsp_vld !== 1'b1 || bus.rsp_op !== head.op || bus.rsp_id !== head.id
          || bus.rsp_hit !== head.hit) begin
        failures++;
        $display("FAIL stall_hold cyc%0d got vld=%b op=%0d id=%0d hit=%b want 1 %0d %0d %b",
                 c, bus.rsp_vld, bus.rsp_op, bus.rsp_id, bus.rsp_hit, head.op, head.id,
                 head.hit);
      end
      @(posedge clk);
      #1;
    end
    fork
      begin
        for (int i = 0; i < 3; i++) send(rand_op(), 1'b1, IdW'($urandom), w);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.rsp_rdy = 1'b1;
      end
    join
    drain();
    checks++;
    if (rsp_seen - base != 8) begin
      failures++; $display("FAIL stall_count got %0d want 8", rsp_seen - base);
    end
  endtask

  task automatic test_ins_dup();
    int w;
    do_reset(1);
    bus.rsp_rdy = 1'b1;
    send(OpIns, 1'b1, IdW'(5), w);
    send(OpIns, 1'b1, IdW'(5), w);
    drain();
    checks++;
    if (bus.occ !== (IdW + 1)'(1)) begin
      failures++; $display("FAIL dup_occ got %0d want 1", bus.occ);
    end
    send(OpDel, 1'b1, IdW'(7), w);
    drain();
    checks += 2;
    if (last_hit !== 1'b0) begin
      failures++; $display("FAIL del_unset_hit got %b want 0", last_hit);
    end
    if (bus.occ !== (IdW + 1)'(1)) begin
      failures++; $display("FAIL del_unset_occ got %0d want 1", bus.occ);
    end
  endtask

  task automatic test_reset_mid();
    int             w;
    int             base;
    logic [IdW-1:0] a;
    do_reset(1);
    a = IdW'($urandom);
    bus.rsp_rdy = 1'b0;
    send(OpIns, 1'b1, a, w);
    for (int i = 0; i < 3; i++) send(OpIns, 1'b1, IdW'($urandom), w);
    checks++;
    if (bus.rsp_vld !== 1'b1) begin
      failures++; $display("FAIL mid_pre_vld got %b want 1", bus.rsp_vld);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    checks += 3;
    if (bus.rsp_vld !== 1'b0 || bus.wrs !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got vld=%b wrs=%b want 0 0", bus.rsp_vld, bus.wrs);
    end
    if (bus.occ !== '0) begin
      failures++; $display("FAIL mid_rst_occ got %0d want 0", bus.occ);
    end
    if (bus.acc_cnt !== '0) begin
      failures++; $display("FAIL mid_rst_acc got %0d want 0", bus.acc_cnt);
    end
    rst = 1'b1;
    base = rsp_seen;
    bus.rsp_rdy = 1'b1;
    repeat (FIFO_DEPTH + 3) @(posedge clk);
    #1;
    checks++;
    if (rsp_seen != base || bus.occ !== '0) begin
      failures++;
      $display("FAIL mid_flush got rsp=%0d occ=%0d want 0 0", rsp_seen - base, bus.occ);
    end
    send(OpChk, 1'b1, a, w);
    drain();
    checks++;
    if (last_hit !== 1'b0 || rsp_seen - base != 1) begin
      failures++;
      $display("FAIL mid_chk got hit=%b rsp=%0d want 0 1", last_hit, rsp_seen - base);
    end
  endtask

  task automatic test_mode0();
    int w;
    int base;
    do_reset(1);
    base = rsp_seen;
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < int'(NId); i++) send(OpIns, 1'b0, IdW'(i), w);
    drain();
    checks += 3;
    if (rsp_seen != base) begin
      failures++; $display("FAIL mode0_rsp got %0d want 0", rsp_seen - base);
    end
    if (bus.occ !== (IdW + 1)'(NId)) begin
      failures++; $display("FAIL mode0_occ got %0d want %0d", bus.occ, NId);
    end
    if (bus.acc_cnt !== CntW'(NId)) begin
      failures++; $display("FAIL mode0_acc got %0d want %0d", bus.acc_cnt, NId);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset(1);
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(rand_op(), 1'b1, IdW'($urandom_range(0, 2)), w);
      checks++;
      if (w != 0) begin
        failures++; $display("FAIL b2b_wait%0d got %0d want 0", i, w);
      end
    end
    drain();
    checks++;
    if (bus.occ !== (IdW + 1)'(model_occ())) begin
      failures++; $display("FAIL b2b_occ got %0d want %0d", bus.occ, model_occ());
    end
  endtask

  task automatic test_random();
    int w;
    bit stop = 1'b0;
    do_reset(1);
    fork
      begin
        for (int i = 0; i < 150; i++)
          send(rand_op(), 1'($urandom), IdW'($urandom), w);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          bus.rsp_rdy = 1'($urandom);
        end
      end
    join
    drain();
    checks += 2;
    if (bus.occ !== (IdW + 1)'(model_occ())) begin
      failures++; $display("FAIL rand_occ got %0d want %0d", bus.occ, model_occ());
    end
    if (bus.acc_cnt !== CntW'(acc_model)) begin
      failures++; $display("FAIL rand_acc got %0d want %0d", bus.acc_cnt, acc_model);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rsp_seen    = 0;
    last_hit    = 1'b0;
    rst         = 1'b0;
    bus.wrm     = 1'b0;
    bus.wop     = OpDel;
    bus.wmo     = 1'b0;
    bus.wid     = '0;
    bus.rsp_rdy = 1'b0;
    model_clear();
    test_reset();
    test_stream();
    test_stall();
    test_ins_dup();
    test_reset_mid();
    test_mode0();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
